refill_way_sel: RTL and testbench

- Downstream consumer of the pseudo-random refill-way source in a set-associative cache miss path.
- Accepts one refill request per miss, together with the set's valid and lock vectors.
- Selection: lowest-index invalid unlocked way if one exists; otherwise the LFSR-chosen way, skipped forward past locked ways.
- Holds the decision on a valid/ready output until the refill controller takes it.

---
 rtl/cache_repl_pkg.sv | 27 ++
 rtl/lfsr_8bit.sv | 27 ++
 rtl/lzc.sv | 35 +++
 rtl/refill_way_sel.sv | 138 +++++++++++++
 tb/tb_refill_way_sel.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_repl_pkg.sv
// Shared types and helpers for the cache refill-way selection logic.
package cache_repl_pkg;

  localparam int unsigned MaxWays    = 8;
  localparam int unsigned MaxWayIdxW = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } repl_state_e;

  // Registered decision; sized for the largest supported associativity,
  // narrower configurations use the low bits only.
  typedef struct packed {
    logic [MaxWays-1:0]    way_oh;
    logic [MaxWayIdxW-1:0] way_bin;
    logic                  evict;
    logic                  err;
  } repl_result_t;

  // Shift-left LFSR step, feedback is XNOR of taps 7,3,2,1 so the
  // all-zero seed is a legal starting point.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ~(v[7] ^ v[3] ^ v[2] ^ v[1])};
  endfunction

endpackage

// File: rtl/lfsr_8bit.sv
// 8-bit pseudo-random source; steps once per enabled cycle.
module lfsr_8bit
  import cache_repl_pkg::*;
#(
  parameter logic [7:0]  Seed     = 8'h00,
  parameter int unsigned OutWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  output logic [OutWidth-1:0] q_o
);

  logic [7:0] lfsr_q;

  // Advance only when enabled; reset returns to the seed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else if (en_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q_o = lfsr_q[OutWidth-1:0];

endmodule

// File: rtl/lzc.sv
// Leading/trailing zero counter. Mode 0 counts trailing zeros, which is
// the index of the lowest set bit.
module lzc #(
  parameter int unsigned Width = 8,
  parameter bit          Mode  = 1'b0,
  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);

  logic [Width-1:0] in_sel;

  // Leading-zero mode is trailing-zero search on the bit-reversed input.
  always_comb begin
    in_sel = '0;
    for (int i = 0; i < Width; i++) begin
      in_sel[i] = Mode ? in_i[Width-1-i] : in_i[i];
    end
  end

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    for (int i = Width - 1; i >= 0; i--) begin
      if (in_sel[i]) begin
        cnt_o   = CntW'(i);
        empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/refill_way_sel.sv
// Refill-way selector: picks the victim way for a cache miss and holds
// the decision on a valid/ready handshake until the refill side takes it.
//
// state | meaning
// IDLE  | ready for a request; decision computed and registered on accept
// OFFER | decision presented on way_*_o; waits for way_ready_i
module refill_way_sel
  import cache_repl_pkg::*;
#(
  parameter int unsigned  NumWays     = 8,
  parameter logic [7:0]   LfsrSeed    = 8'h00,
  localparam int unsigned WayIdxWidth = $clog2(NumWays)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [NumWays-1:0]     valid_ways_i,
  input  logic [NumWays-1:0]     lock_ways_i,
  output logic                   way_valid_o,
  input  logic                   way_ready_i,
  output logic [NumWays-1:0]     way_oh_o,
  output logic [WayIdxWidth-1:0] way_bin_o,
  output logic                   evict_o,
  output logic                   err_o
);

  repl_state_e               state_q, state_d;
  repl_result_t              result_q, sel_d;
  logic                      accept;
  logic [WayIdxWidth-1:0]    rnd_way;
  logic [NumWays-1:0]        free_ways;
  logic [WayIdxWidth-1:0]    free_idx;
  logic                      free_none;
  logic [WayIdxWidth-1:0]    skip_idx;
  logic [WayIdxWidth-1:0]    sel_bin;

  assign accept    = req_valid_i & req_ready_o;
  assign free_ways = ~valid_ways_i & ~lock_ways_i;

  // The random source steps once per accepted request; the decision uses
  // the value present before that step.
  lfsr_8bit #(
    .Seed    (LfsrSeed),
    .OutWidth(WayIdxWidth)
  ) u_lfsr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (accept),
    .q_o   (rnd_way)
  );

  lzc #(
    .Width(NumWays),
    .Mode (1'b0)
  ) u_free_lzc (
    .in_i   (free_ways),
    .cnt_o  (free_idx),
    .empty_o(free_none)
  );

  // First unlocked way at or after the random pick, wrapping around.
  // Index arithmetic wraps for free because NumWays is a power of two.
  always_comb begin
    logic                   found;
    logic [WayIdxWidth-1:0] idx;
    found    = 1'b0;
    idx      = '0;
    skip_idx = '0;
    for (int k = 0; k < NumWays; k++) begin
      idx = rnd_way + WayIdxWidth'(k);
      if (!found && !lock_ways_i[idx]) begin
        found    = 1'b1;
        skip_idx = idx;
      end
    end
  end

  // Combine the free-way and random paths into the registered result.
  always_comb begin
    sel_d   = '0;
    sel_bin = '0;
    if (&lock_ways_i) begin
      sel_d.err = 1'b1;
    end else begin
      sel_bin           = free_none ? skip_idx : free_idx;
      sel_d.evict       = free_none;
      sel_d.way_bin     = MaxWayIdxW'(sel_bin);
      sel_d.way_oh[sel_bin] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    way_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = OFFER;
        end
      end
      OFFER: begin
        way_valid_o = 1'b1;
        if (way_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the decision on accept; it stays frozen through OFFER.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
    end else if (accept) begin
      result_q <= sel_d;
    end
  end

  assign way_oh_o  = result_q.way_oh[NumWays-1:0];
  assign way_bin_o = result_q.way_bin[WayIdxWidth-1:0];
  assign evict_o   = result_q.evict;
  assign err_o     = result_q.err;

endmodule

// File: tb/tb_refill_way_sel.sv
// Self-checking bench for refill_way_sel (NumWays=8, seed 0).
module tb_refill_way_sel;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [7:0] valid_ways_i = '0;
  logic [7:0] lock_ways_i = '0;
  logic       way_valid_o;
  logic       way_ready_i = 1'b0;
  logic [7:0] way_oh_o;
  logic [2:0] way_bin_o;
  logic       evict_o;
  logic       err_o;

  refill_way_sel #(
    .NumWays (8),
    .LfsrSeed(8'h00)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .valid_ways_i(valid_ways_i),
    .lock_ways_i (lock_ways_i),
    .way_valid_o (way_valid_o),
    .way_ready_i (way_ready_i),
    .way_oh_o    (way_oh_o),
    .way_bin_o   (way_bin_o),
    .evict_o     (evict_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         rst;
    logic [7:0] valid;
    logic [7:0] lock;
    logic [2:0] bin;
    logic [7:0] oh;
    logic       ev;
    logic       err;
  } vec_t;

  typedef struct {
    logic [2:0] bin;
    logic [7:0] oh;
    logic       ev;
    logic       err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    req_valid_i = 1'b0;
    way_ready_i = 1'b0;
    rst_ni      = 1'b0;
    #2;
    check("rst_way_valid", way_valid_o, 0);
    check("rst_way_oh", way_oh_o, 0);
    check("rst_way_bin", way_bin_o, 0);
    check("rst_evict", evict_o, 0);
    check("rst_err", err_o, 0);
    sb.delete();
    step();
    rst_ni = 1'b1;
    step();
    check("rst_req_ready", req_ready_o, 1);
  endtask

  // Compare the presented decision against the oldest expectation.
  task automatic pop_compare(input string tag);
    exp_t e;
    if (!(way_valid_o && way_ready_i)) begin
      check({tag, "_handshake"}, {way_valid_o, way_ready_i}, 2'b11);
    end else if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_sb: got decision with no expectation queued", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_bin"}, way_bin_o, e.bin);
      check({tag, "_oh"}, way_oh_o, e.oh);
      check({tag, "_evict"}, evict_o, e.ev);
      check({tag, "_err"}, err_o, e.err);
    end
  endtask

  // One full request/offer/handshake with ready already high.
  task automatic run_req(input vec_t v, input string tag);
    exp_t e;
    valid_ways_i = v.valid;
    lock_ways_i  = v.lock;
    way_ready_i  = 1'b1;
    req_valid_i  = 1'b1;
    #1;
    check({tag, "_req_ready"}, req_ready_o, 1);
    if (req_valid_i && req_ready_o) begin
      e.bin = v.bin; e.oh = v.oh; e.ev = v.ev; e.err = v.err;
      sb.push_back(e);
    end
    step();
    req_valid_i  = 1'b0;
    valid_ways_i = ~v.valid;
    lock_ways_i  = ~v.lock;
    #1;
    check({tag, "_latency"}, way_valid_o, 1);
    check({tag, "_busy"}, req_ready_o, 0);
    pop_compare(tag);
    step();
    check({tag, "_idle_valid"}, way_valid_o, 0);
    check({tag, "_idle_ready"}, req_ready_o, 1);
  endtask

  initial begin
    // LFSR from seed 0 (pre-advance values): 00,01,03,06,0D,1B,37,6F
    vecs[0]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 8'h01, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'hFF, 8'h00, 3'd1, 8'h02, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 8'h00, 3'd3, 8'h08, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'hFF, 8'h00, 3'd6, 8'h40, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'hFF, 8'h60, 3'd7, 8'h80, 1'b1, 1'b0};  // r=5, skip 5,6
    vecs[5]  = '{1'b0, 8'hFF, 8'hF8, 3'd0, 8'h01, 1'b1, 1'b0};  // r=3, wrap to 0
    vecs[6]  = '{1'b0, 8'hFF, 8'hFF, 3'd0, 8'h00, 1'b0, 1'b1};  // all locked
    vecs[7]  = '{1'b0, 8'h7F, 8'h00, 3'd7, 8'h80, 1'b0, 1'b0};  // free way 7
    vecs[8]  = '{1'b1, 8'hF7, 8'h00, 3'd3, 8'h08, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'hFF, 8'h00, 3'd1, 8'h02, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'hFF, 8'h01, 3'd1, 8'h02, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'hFF, 8'h06, 3'd3, 8'h08, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 8'h03, 3'd2, 8'h04, 1'b0, 1'b0};  // free but locked low
    vecs[13] = '{1'b0, 8'h0F, 8'hF0, 3'd0, 8'h01, 1'b1, 1'b0};  // r=6, wrap to 0

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset();
      run_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Stall in OFFER with inputs toggling; decision must not move and the
    // LFSR must not step while req_valid_i stays high.
    do_reset();
    begin
      exp_t e;
      valid_ways_i = 8'hFF;
      lock_ways_i  = 8'h00;
      req_valid_i  = 1'b1;
      way_ready_i  = 1'b0;
      #1;
      check("hold_req_ready", req_ready_o, 1);
      e.bin = 3'd0; e.oh = 8'h01; e.ev = 1'b1; e.err = 1'b0;
      sb.push_back(e);
      step();
      for (int c = 0; c < 5; c++) begin
        valid_ways_i = 8'($urandom);
        lock_ways_i  = 8'($urandom);
        #1;
        check("hold_valid", way_valid_o, 1);
        check("hold_ready", req_ready_o, 0);
        check("hold_bin", way_bin_o, 3'd0);
        check("hold_oh", way_oh_o, 8'h01);
        check("hold_evict", evict_o, 1);
        step();
      end
      req_valid_i = 1'b0;
      way_ready_i = 1'b1;
      #1;
      pop_compare("hold_release");
      step();
      check("hold_idle_valid", way_valid_o, 0);
      check("hold_idle_ready", req_ready_o, 1);
      run_req('{1'b0, 8'hFF, 8'h00, 3'd1, 8'h02, 1'b1, 1'b0}, "after_hold");
    end

    // Reset in the middle of OFFER drops the decision and reseeds.
    do_reset();
    run_req('{1'b0, 8'hFF, 8'h00, 3'd0, 8'h01, 1'b1, 1'b0}, "pre_rst");
    valid_ways_i = 8'h00;
    lock_ways_i  = 8'h00;
    way_ready_i  = 1'b0;
    req_valid_i  = 1'b1;
    step();
    req_valid_i = 1'b0;
    check("mid_offer_valid", way_valid_o, 1);
    check("mid_offer_evict", evict_o, 0);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", way_valid_o, 0);
    check("mid_rst_oh", way_oh_o, 0);
    check("mid_rst_ready", req_ready_o, 1);
    sb.delete();
    step();
    rst_ni = 1'b1;
    step();
    run_req('{1'b0, 8'hFF, 8'h00, 3'd0, 8'h01, 1'b1, 1'b0}, "post_rst");

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
